// File: rtl/fpm_pkg.sv
// rtl/fpm_pkg.sv - shared encodings and constants for the fp multiplier front stage
package fpm_pkg;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } fpm_class_e;

  localparam int FPM_EXP_W  = 8;
  localparam int FPM_MAN_W  = 23;
  localparam int FPM_BIAS   = 127;
  localparam int FPM_OEXP_W = 10;

  localparam logic [FPM_EXP_W-1:0] FPM_EXP_ONES = {FPM_EXP_W{1'b1}};

  // NaN wins over everything, including the inf*zero invalid case.
  function automatic fpm_class_e fpm_resolve_class(
    input logic za, input logic ia, input logic na,
    input logic zb, input logic ib, input logic nb
  );
    if (na || nb || (ia && zb) || (za && ib)) return CLS_NAN;
    else if (ia || ib)                        return CLS_INF;
    else if (za || zb)                        return CLS_ZERO;
    else                                      return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/fpm_unpack.sv
// rtl/fpm_unpack.sv - combinational binary32 operand unpack and classify
module fpm_unpack
  import fpm_pkg::*;
#(
  parameter int EXP_W = FPM_EXP_W,
  parameter int MAN_W = FPM_MAN_W
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp,
  output logic [MAN_W:0]       man,
  output logic                 is_zero,
  output logic                 is_inf,
  output logic                 is_nan
);

  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

  logic [MAN_W-1:0] frac;

  assign sign = op[EXP_W+MAN_W];
  assign exp  = op[MAN_W +: EXP_W];
  assign frac = op[MAN_W-1:0];
  assign man  = {1'b1, frac};

  // Denormals share exponent 0 with true zero and are flushed along with it.
  assign is_zero = (exp == '0);
  assign is_inf  = (exp == EXP_MAX) && (frac == '0);
  assign is_nan  = (exp == EXP_MAX) && (frac != '0);

endmodule

// File: rtl/prefix_add32.sv
// rtl/prefix_add32.sv - 32-bit Kogge-Stone parallel-prefix adder
module prefix_add32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] sum
);

  logic [5:0][31:0] g;
  logic [4:0][31:0] p;
  logic             unused_ks;

  // Carry-in folds into bit 0's generate so the prefix tree stays uniform.
  assign p[0]    = x ^ y;
  assign g[0][0] = (x[0] & y[0]) | (p[0][0] & cin);
  assign g[0][31:1] = x[31:1] & y[31:1];

  for (genvar l = 0; l < 5; l++) begin : g_level
    for (genvar i = 0; i < 32; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_merge
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
        if (l < 4) begin : g_pm
          assign p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
        end
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        if (l < 4) begin : g_pp
          assign p[l+1][i] = p[l][i];
        end
      end
    end
  end

  assign sum       = p[0] ^ {g[5][30:0], cin};
  assign unused_ks = ^{p[4][15:0], g[5][31]};

endmodule

// File: rtl/fpm_exp_stage.sv
// rtl/fpm_exp_stage.sv - two-stage unpack, classify and exponent-add front end
module fpm_exp_stage
  import fpm_pkg::*;
#(
  parameter int EXP_W = FPM_EXP_W,
  parameter int MAN_W = FPM_MAN_W,
  parameter int BIAS  = FPM_BIAS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           a,
  input  logic [31:0]           b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [FPM_OEXP_W-1:0] out_exp,
  output logic [MAN_W:0]        out_ma,
  output logic [MAN_W:0]        out_mb,
  output logic [1:0]            out_class
);

  localparam logic [31:0] NEG_BIAS = ~32'(BIAS) + 32'd1;

  logic             ua_sign, ub_sign;
  logic [EXP_W-1:0] ua_exp, ub_exp;
  logic [MAN_W:0]   ua_man, ub_man;
  logic             ua_zero, ua_inf, ua_nan;
  logic             ub_zero, ub_inf, ub_nan;

  fpm_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .op(a), .sign(ua_sign), .exp(ua_exp), .man(ua_man),
    .is_zero(ua_zero), .is_inf(ua_inf), .is_nan(ua_nan)
  );

  fpm_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .op(b), .sign(ub_sign), .exp(ub_exp), .man(ub_man),
    .is_zero(ub_zero), .is_inf(ub_inf), .is_nan(ub_nan)
  );

  fpm_class_e cls_d;
  logic       sign_d;

  always_comb begin
    cls_d  = fpm_resolve_class(ua_zero, ua_inf, ua_nan, ub_zero, ub_inf, ub_nan);
    sign_d = (cls_d == CLS_NAN) ? 1'b0 : (ua_sign ^ ub_sign);
  end

  logic [31:0] esum_full;

  prefix_add32 u_add_esum (
    .x({{(32-EXP_W){1'b0}}, ua_exp}),
    .y({{(32-EXP_W){1'b0}}, ub_exp}),
    .cin(1'b0),
    .sum(esum_full)
  );

  logic v1, v2, adv1, adv2;

  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  logic             s1_sign;
  fpm_class_e       s1_class;
  logic [MAN_W:0]   s1_ma, s1_mb;
  logic [EXP_W:0]   s1_esum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      s1_sign  <= 1'b0;
      s1_class <= CLS_NORMAL;
      s1_ma    <= '0;
      s1_mb    <= '0;
      s1_esum  <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_sign  <= sign_d;
        s1_class <= cls_d;
        s1_ma    <= (cls_d == CLS_NORMAL) ? ua_man : '0;
        s1_mb    <= (cls_d == CLS_NORMAL) ? ub_man : '0;
        s1_esum  <= esum_full[EXP_W:0];
      end
    end
  end

  logic [31:0] exp_full;

  // esum - BIAS as an add of the bias' two's complement; low bits form a signed result.
  prefix_add32 u_add_bias (
    .x({{(31-EXP_W){1'b0}}, s1_esum}),
    .y(NEG_BIAS),
    .cin(1'b0),
    .sum(exp_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_ma    <= '0;
      out_mb    <= '0;
      out_class <= 2'd0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_sign  <= s1_sign;
        out_class <= s1_class;
        out_ma    <= s1_ma;
        out_mb    <= s1_mb;
        out_exp   <= (s1_class == CLS_NORMAL) ? exp_full[FPM_OEXP_W-1:0] : '0;
      end
    end
  end

  logic unused_hi;
  assign unused_hi = ^{esum_full[31:EXP_W+1], exp_full[31:FPM_OEXP_W]};

endmodule

// File: tb/tb_fpm_exp_stage.sv
// tb/tb_fpm_exp_stage.sv - directed table, backpressure, random and reset checks
module tb_fpm_exp_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        out_valid, out_ready;
  logic        out_sign;
  logic [9:0]  out_exp;
  logic [23:0] out_ma, out_mb;
  logic [1:0]  out_class;

  always #5 clk = ~clk;

  fpm_exp_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp),
    .out_ma(out_ma), .out_mb(out_mb), .out_class(out_class)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [1:0]  cls;
  } vec_t;

  vec_t vecs [9];
  vec_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_in     = 0;
  int   n_out    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ia, input logic [31:0] ib, input logic s,
                              input logic [9:0] e, input logic [23:0] ma, input logic [23:0] mb,
                              input logic [1:0] c);
    vec_t v;
    v.a = ia; v.b = ib; v.sign = s; v.exp = e; v.ma = ma; v.mb = mb; v.cls = c;
    return v;
  endfunction

  function automatic vec_t model(input logic [31:0] ia, input logic [31:0] ib);
    vec_t v;
    int   ea, eb, e;
    logic za, zb, fa, fb, na, nb;
    ea = int'(ia[30:23]);
    eb = int'(ib[30:23]);
    za = (ea == 0);
    zb = (eb == 0);
    fa = (ea == 255) && (ia[22:0] == 0);
    fb = (eb == 255) && (ib[22:0] == 0);
    na = (ea == 255) && (ia[22:0] != 0);
    nb = (eb == 255) && (ib[22:0] != 0);
    v = mk(ia, ib, ia[31] ^ ib[31], 10'd0, 24'd0, 24'd0, 2'd0);
    if (na || nb || (fa && zb) || (za && fb)) begin
      v.cls = 2'd3; v.sign = 1'b0;
    end else if (fa || fb) v.cls = 2'd2;
    else if (za || zb)     v.cls = 2'd1;
    else begin
      e = ea + eb - 127;
      v.exp = e[9:0];
      v.ma = {1'b1, ia[22:0]};
      v.mb = {1'b1, ib[22:0]};
    end
    return v;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[30:23] = 8'd0;
      1: begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
      2: begin r[30:23] = 8'hFF; r[0] = 1'b1; end
      default: r[30:23] = 8'($urandom_range(1, 254));
    endcase
    return r;
  endfunction

  task automatic step(input logic iv, input vec_t v, input logic ordy, output logic took, output logic ov);
    vec_t e;
    @(negedge clk);
    in_valid  = iv;
    a         = v.a;
    b         = v.b;
    out_ready = ordy;
    #1;
    took = iv && in_ready;
    ov   = out_valid;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("spurious_output", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_sign",  32'(out_sign),  32'(e.sign));
        check("out_exp",   32'(out_exp),   32'(e.exp));
        check("out_ma",    32'(out_ma),    32'(e.ma));
        check("out_mb",    32'(out_mb),    32'(e.mb));
        check("out_class", 32'(out_class), 32'(e.cls));
      end
    end
    if (took) begin
      exp_q.push_back(v);
      n_in++;
    end
  endtask

  task automatic drain();
    logic t, o;
    for (int k = 0; k < 12 && exp_q.size() != 0; k++) step(1'b0, vecs[0], 1'b1, t, o);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic took, ov, first_took;
    int   acc, r, seen, sent;
    vec_t bp [4];
    vec_t pend;

    vecs[0] = mk(32'h3FC00000, 32'h40000000, 1'b0, 10'h080, 24'hC00000, 24'h800000, 2'd0);
    vecs[1] = mk(32'hBF800000, 32'h3F800000, 1'b1, 10'h07F, 24'h800000, 24'h800000, 2'd0);
    vecs[2] = mk(32'h00800000, 32'h00800000, 1'b0, 10'h383, 24'h800000, 24'h800000, 2'd0);
    vecs[3] = mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 10'h17D, 24'hFFFFFF, 24'hFFFFFF, 2'd0);
    vecs[4] = mk(32'h7F800000, 32'h00000000, 1'b0, 10'h000, 24'h000000, 24'h000000, 2'd3);
    vecs[5] = mk(32'hFF800000, 32'h3F800000, 1'b1, 10'h000, 24'h000000, 24'h000000, 2'd2);
    vecs[6] = mk(32'h00000001, 32'h40000000, 1'b0, 10'h000, 24'h000000, 24'h000000, 2'd1);
    vecs[7] = mk(32'h7FC00000, 32'hBF800000, 1'b0, 10'h000, 24'h000000, 24'h000000, 2'd3);
    vecs[8] = mk(32'h80000000, 32'h3F800000, 1'b1, 10'h000, 24'h000000, 24'h000000, 2'd1);

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_sign",  32'(out_sign),  32'd0);
    check("rst_out_exp",   32'(out_exp),   32'd0);
    check("rst_out_ma",    32'(out_ma),    32'd0);
    check("rst_out_mb",    32'(out_mb),    32'd0);
    check("rst_out_class", 32'(out_class), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: presented in one cycle, valid two cycles later.
    step(1'b1, vecs[0], 1'b1, took, ov);
    check("lat_accept", 32'(took), 32'd1);
    step(1'b0, vecs[0], 1'b1, took, ov);
    check("lat_valid_c1", 32'(ov), 32'd0);
    step(1'b0, vecs[0], 1'b1, took, ov);
    check("lat_valid_c2", 32'(ov), 32'd1);

    for (int i = 1; i < 9; i++) begin
      step(1'b1, vecs[i], 1'b1, took, ov);
      check("stream_accept", 32'(took), 32'd1);
    end
    drain();

    // Backpressure: only two pairs fit while the output is stalled.
    bp[0] = vecs[1]; bp[1] = vecs[2]; bp[2] = vecs[3]; bp[3] = vecs[0];
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, bp[acc], 1'b0, took, ov);
      if (took) acc++;
    end
    check("bp_accepted", 32'(acc), 32'd2);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    seen = n_out;
    r = 0;
    first_took = 1'b0;
    while ((acc < 4 || exp_q.size() != 0) && r < 10) begin
      step(acc < 4, bp[acc < 4 ? acc : 0], 1'b1, took, ov);
      if (r == 0) first_took = took;
      if (took) acc++;
      r++;
    end
    check("bp_simul_accept", 32'(first_took), 32'd1);
    check("bp_drain_cycles", 32'(r), 32'd4);
    check("bp_drain_count", 32'(n_out - seen), 32'd4);

    // Random stream with random backpressure against the model.
    sent = 0;
    pend = model(rand_op(), rand_op());
    for (int k = 0; k < 2000 && sent < 60; k++) begin
      logic iv;
      iv = ($urandom_range(0, 4) != 0);
      step(iv, pend, ($urandom_range(0, 3) != 0), took, ov);
      if (took) begin
        sent++;
        pend = model(rand_op(), rand_op());
      end
    end
    check("rand_sent", 32'(sent), 32'd60);
    drain();
    check("rand_in_eq_out", 32'(n_out), 32'(n_in));

    // Reset with both stages full discards in-flight pairs.
    acc = 0;
    for (int k = 0; k < 4 && acc < 2; k++) begin
      step(1'b1, vecs[k], 1'b0, took, ov);
      if (took) acc++;
    end
    @(negedge clk);
    check("full_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_exp",   32'(out_exp),   32'd0);
    check("midrst_out_class", 32'(out_class), 32'd0);
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, vecs[0], 1'b1, took, ov);
      if (ov) seen++;
    end
    check("postrst_no_stale", 32'(seen), 32'd0);
    check("postrst_in_ready", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
